plic_gateway: RTL and testbench
===============================

PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 32: number of sources, 2..32; source 0 is reserved.
REQ-002 SHALL have parameter IRQ_WID, default 5: claim/complete ID width, with 2**IRQ_WID >= IRQ_NUM.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port irq_i, input, IRQ_NUM bits: raw, asynchronous interrupt request lines.
REQ-006 SHALL have port trig_i, input, IRQ_NUM bits: per-source trigger type, 1 = rising edge, 0 = high level.
REQ-007 SHALL have port claim_vld_i, input, 1 bit: claim strobe from the PLIC core.
REQ-008 SHALL have port claim_id_i, input, IRQ_WID bits: ID being claimed.
REQ-009 SHALL have port comp_vld_i, input, 1 bit: complete strobe from the PLIC core.
REQ-010 SHALL have port comp_id_i, input, IRQ_WID bits: ID being completed.
REQ-011 SHALL have port ip_o, output, IRQ_NUM bits: pending vector; this is the PLIC_IP source.
REQ-012 SHALL have port busy_o, output, IRQ_NUM bits: per-source in-service flag.

Function
REQ-013 SHALL synchronise each irq_i bit through 2 flops (s2), plus 1 history flop (s3).
REQ-014 SHALL compute per-source request: level mode = s2; edge mode = s2 & ~s3.
REQ-015 SHALL give each source i >= 1 a 3-state FSM: IDLE (ip=0, busy=0), PEND (ip=1, busy=0), BUSY (ip=0, busy=1).
REQ-016 IDLE -> PEND SHALL occur on the edge where the request is 1; irq_i high before edge N gives ip_o = 1 after edge N+2.
REQ-017 PEND -> BUSY SHALL occur on the edge where claim_vld_i = 1 and claim_id_i = i; ip_o drops 1 cycle after the claim.
REQ-018 BUSY -> IDLE SHALL occur on the edge where comp_vld_i = 1 and comp_id_i = i; the FSM may re-enter PEND no earlier than the following edge.
REQ-019 In level mode, a request still high after completion SHALL re-pend 1 cycle after IDLE is reached.
REQ-020 Claim of a source not in PEND SHALL be ignored; complete of a source not in BUSY SHALL be ignored.
REQ-021 IDs 0 and >= IRQ_NUM SHALL be ignored for both claim and complete.
REQ-022 Claim and complete of the same ID in one cycle SHALL be evaluated independently against the current state: PEND takes only the claim, BUSY takes only the complete.
REQ-023 Claim and complete of different IDs in one cycle SHALL both be applied.
REQ-024 Edge requests arriving in PEND or BUSY SHALL be dropped unless the edge counter (REQ-029) is compiled in.
REQ-025 A change of trig_i SHALL affect request detection only; it SHALL NOT change FSM state.
REQ-026 ip_o[0] and busy_o[0] SHALL be constant 0.

Reset
REQ-027 While rst_i = 1, SHALL clear all synchroniser, history and edge-counter flops, force every FSM to IDLE, and drive ip_o = 0 and busy_o = 0.
REQ-028 Reset asserted in PEND or BUSY SHALL discard the in-flight interrupt with no replay; after release, an irq_i line already high SHALL be detected in both edge and level modes (history flop = 0).

Configuration
REQ-029 Macro PLIC_GW_EDGE_CNT_EN defined: each source SHALL have a 4-bit saturating counter (max 15) that increments on each edge request seen in PEND or BUSY.
REQ-030 With the macro defined, on completion with counter > 0 (including an edge in the same cycle), the FSM SHALL go BUSY -> PEND directly and decrement the counter, net of any same-cycle increment.
REQ-031 Macro PLIC_GW_EDGE_CNT_EN undefined: no counter SHALL be present and behaviour SHALL follow REQ-024.

Verification
REQ-032 Level, src 3: irq_i[3] high before edge 0 -> ip_o[3] = 1 after edge 2; claim id 3 -> ip_o[3] = 0, busy_o[3] = 1; complete id 3 with line still high -> ip_o[3] = 1 again 2 edges after the complete.
REQ-033 Edge, src 7: pulse 1 -> PEND; claim; 3 more pulses while BUSY; complete -> macro undefined: IDLE, ip_o[7] = 0; macro defined: 3 further pending/claim/complete rounds, then IDLE.
REQ-034 Src 5 in PEND, claim id 5 and complete id 5 in the same cycle -> BUSY; a later complete id 5 -> IDLE.
REQ-035 Claim id 0, claim id 31 with IRQ_NUM = 16, and complete of an IDLE source -> no change on ip_o or busy_o.
REQ-036 rst_i pulsed mid-cycle while src 2 is BUSY -> ip_o = busy_o = 0 immediately, asynchronously; level line held high -> ip_o[2] = 1 three edges after release.
REQ-037 Edge src 9 with macro defined: 20 pulses while BUSY -> counter saturates at 15 -> exactly 15 replays.

Source files
------------

// File: rtl/plic_gateway.sv
// ---------------------------------------------------------------------------------------------
// plic_gateway
//
// Interrupt gateway in front of a PLIC core. Each raw request line is synchronised, turned into
// a per-source request (level or rising edge), and tracked by a small IDLE/PEND/BUSY state
// machine driven by the core's claim and complete strobes.
//
// Build option:
//   PLIC_GW_EDGE_CNT_EN  When defined, every source gets a 4-bit saturating counter that
//                        remembers edge requests arriving while the source is PEND or BUSY and
//                        replays them (BUSY -> PEND) on completion. When undefined those edges
//                        are dropped.
//
// Parameters:
//   IRQ_NUM   number of sources (2..32); source 0 is reserved and never pends
//   IRQ_WID   width of the claim/complete IDs, 2**IRQ_WID >= IRQ_NUM
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   irq_i        raw asynchronous interrupt request lines
//   trig_i       per-source trigger type: 1 = rising edge, 0 = high level
//   claim_vld_i  claim strobe from the core, with claim_id_i
//   comp_vld_i   complete strobe from the core, with comp_id_i
//   ip_o         pending vector (source is in PEND)
//   busy_o       in-service vector (source is in BUSY)
// ---------------------------------------------------------------------------------------------
module plic_gateway #(
    parameter int unsigned IRQ_NUM = 32,
    parameter int unsigned IRQ_WID = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic [IRQ_NUM-1:0] trig_i,
    input  logic               claim_vld_i,
    input  logic [IRQ_WID-1:0] claim_id_i,
    input  logic               comp_vld_i,
    input  logic [IRQ_WID-1:0] comp_id_i,
    output logic [IRQ_NUM-1:0] ip_o,
    output logic [IRQ_NUM-1:0] busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StBusy
    } gw_state_e;

    // Two-flop synchroniser plus one history flop for edge detection.
    logic [IRQ_NUM-1:0] sync1_q;
    logic [IRQ_NUM-1:0] sync2_q;
    logic [IRQ_NUM-1:0] hist_q;

    logic [IRQ_NUM-1:0] req;
    logic [IRQ_NUM-1:0] claim_hit;
    logic [IRQ_NUM-1:0] comp_hit;

    gw_state_e          state_q [IRQ_NUM];
    gw_state_e          state_d [IRQ_NUM];
    logic [IRQ_NUM-1:0] ip_q;
    logic [IRQ_NUM-1:0] busy_q;

`ifdef PLIC_GW_EDGE_CNT_EN
    logic [3:0] cnt_q [IRQ_NUM];
    logic [3:0] cnt_d [IRQ_NUM];
`endif

    // Request and ID decode. IDs >= IRQ_NUM never match any index; ID 0 matches only the
    // reserved source, whose state is pinned to idle below.
    always_comb begin
        req       = '0;
        claim_hit = '0;
        comp_hit  = '0;
        for (int i = 0; i < int'(IRQ_NUM); i++) begin
            req[i]       = trig_i[i] ? (sync2_q[i] & ~hist_q[i]) : sync2_q[i];
            claim_hit[i] = claim_vld_i && (claim_id_i == IRQ_WID'(i));
            comp_hit[i]  = comp_vld_i && (comp_id_i == IRQ_WID'(i));
        end
    end

    // Next-state logic. Claim is only honoured in PEND and complete only in BUSY, so a
    // same-ID claim+complete in one cycle resolves naturally against the current state.
    always_comb begin
        logic edge_req;
        edge_req = 1'b0;
        for (int i = 0; i < int'(IRQ_NUM); i++) begin
            state_d[i] = state_q[i];
            edge_req   = trig_i[i] & req[i];
`ifdef PLIC_GW_EDGE_CNT_EN
            cnt_d[i] = cnt_q[i];
`endif
            case (state_q[i])
                StIdle: begin
                    if (req[i]) begin
                        state_d[i] = StPend;
                    end
                end
                StPend: begin
                    if (claim_hit[i]) begin
                        state_d[i] = StBusy;
                    end
`ifdef PLIC_GW_EDGE_CNT_EN
                    if (edge_req && (cnt_q[i] != 4'd15)) begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
`endif
                end
                StBusy: begin
`ifdef PLIC_GW_EDGE_CNT_EN
                    if (comp_hit[i]) begin
                        if ((cnt_q[i] != 4'd0) || edge_req) begin
                            // Replay one stored edge; a same-cycle edge cancels the decrement.
                            state_d[i] = StPend;
                            cnt_d[i]   = edge_req ? cnt_q[i] : (cnt_q[i] - 4'd1);
                        end else begin
                            state_d[i] = StIdle;
                        end
                    end else if (edge_req && (cnt_q[i] != 4'd15)) begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
`else
                    if (comp_hit[i]) begin
                        state_d[i] = StIdle;
                    end
`endif
                end
                default: state_d[i] = StIdle;
            endcase
            if (i == 0) begin
                state_d[i] = StIdle;
`ifdef PLIC_GW_EDGE_CNT_EN
                cnt_d[i] = 4'd0;
`endif
            end
        end
    end

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            ip_q    <= '0;
            busy_q  <= '0;
            for (int i = 0; i < int'(IRQ_NUM); i++) begin
                state_q[i] <= StIdle;
`ifdef PLIC_GW_EDGE_CNT_EN
                cnt_q[i] <= 4'd0;
`endif
            end
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            for (int i = 0; i < int'(IRQ_NUM); i++) begin
                state_q[i] <= state_d[i];
                ip_q[i]    <= (state_d[i] == StPend);
                busy_q[i]  <= (state_d[i] == StBusy);
`ifdef PLIC_GW_EDGE_CNT_EN
                cnt_q[i] <= cnt_d[i];
`endif
            end
        end
    end

    assign ip_o   = ip_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_plic_gateway.sv
// ---------------------------------------------------------------------------------------------
// tb_plic_gateway
//
// Directed bench for plic_gateway (IRQ_NUM = 16, IRQ_WID = 5). Inputs change 1 time unit after
// the rising edge and outputs are sampled at the same point, so each tick() consumes one edge.
// ---------------------------------------------------------------------------------------------
module tb_plic_gateway;

    localparam int unsigned IRQ_NUM = 16;
    localparam int unsigned IRQ_WID = 5;

    logic               clk;
    logic               rst;
    logic [IRQ_NUM-1:0] irq;
    logic [IRQ_NUM-1:0] trig;
    logic               claim_vld;
    logic [IRQ_WID-1:0] claim_id;
    logic               comp_vld;
    logic [IRQ_WID-1:0] comp_id;
    logic [IRQ_NUM-1:0] ip;
    logic [IRQ_NUM-1:0] busy;

    int errors = 0;
    int checks = 0;

    plic_gateway #(
        .IRQ_NUM(IRQ_NUM),
        .IRQ_WID(IRQ_WID)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .irq_i      (irq),
        .trig_i     (trig),
        .claim_vld_i(claim_vld),
        .claim_id_i (claim_id),
        .comp_vld_i (comp_vld),
        .comp_id_i  (comp_id),
        .ip_o       (ip),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input int id);
        claim_vld = 1'b1;
        claim_id  = IRQ_WID'(id);
        tick();
        claim_vld = 1'b0;
    endtask

    task automatic comp(input int id);
        comp_vld = 1'b1;
        comp_id  = IRQ_WID'(id);
        tick();
        comp_vld = 1'b0;
    endtask

    task automatic pulse(input int src);
        irq[src] = 1'b1;
        tick();
        irq[src] = 1'b0;
        tick();
    endtask

    int replays;
    int exp_replays;

    initial begin
        rst       = 1'b1;
        irq       = '0;
        trig      = '0;
        claim_vld = 1'b0;
        claim_id  = '0;
        comp_vld  = 1'b0;
        comp_id   = '0;
        tick();
        tick();
        check("reset_ip", 32'(ip), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();

        // Level source 3: pend latency, claim, re-pend after complete with line still high.
        irq[3] = 1'b1;
        tick();
        check("lvl3_e0", 32'(ip[3]), 32'h0);
        tick();
        check("lvl3_e1", 32'(ip[3]), 32'h0);
        tick();
        check("lvl3_e2_pend", 32'(ip[3]), 32'h1);
        claim(3);
        check("lvl3_claim_ip", 32'(ip[3]), 32'h0);
        check("lvl3_claim_busy", 32'(busy[3]), 32'h1);
        comp(3);
        check("lvl3_comp_idle", 32'({ip[3], busy[3]}), 32'h0);
        tick();
        check("lvl3_repend", 32'(ip[3]), 32'h1);
        irq[3] = 1'b0;
        claim(3);
        tick();
        comp(3);
        tick();
        check("lvl3_clean", 32'({ip[3], busy[3]}), 32'h0);

        // Source 5: claim and complete of the same ID in one cycle while PEND.
        irq[5] = 1'b1;
        tick();
        tick();
        tick();
        check("s5_pend", 32'(ip[5]), 32'h1);
        irq[5]    = 1'b0;
        claim_vld = 1'b1;
        claim_id  = 5'd5;
        comp_vld  = 1'b1;
        comp_id   = 5'd5;
        tick();
        claim_vld = 1'b0;
        comp_vld  = 1'b0;
        check("s5_same_cycle", 32'({ip[5], busy[5]}), 32'h1);
        tick();
        comp(5);
        check("s5_comp", 32'({ip[5], busy[5]}), 32'h0);

        // Ignored IDs: 0, 31 (>= IRQ_NUM), complete of IDLE and of PEND sources.
        irq[15] = 1'b1;
        tick();
        tick();
        tick();
        check("s15_pend", 32'(ip), 32'h8000);
        claim(0);
        check("claim0_ip", 32'(ip), 32'h8000);
        claim(31);
        check("claim31_ip", 32'(ip), 32'h8000);
        check("claim31_busy", 32'(busy), 32'h0);
        comp(9);
        check("comp_idle_ip", 32'(ip), 32'h8000);
        comp(15);
        check("comp_pend_ip", 32'(ip), 32'h8000);
        check("comp_pend_busy", 32'(busy), 32'h0);
        claim(15);
        check("s15_busy", 32'(busy), 32'h8000);
        irq[15] = 1'b0;
        irq[4]  = 1'b1;
        tick();
        tick();
        tick();
        check("s4_pend", 32'(ip), 32'h0010);
        // Claim 4 and complete 15 together.
        claim_vld = 1'b1;
        claim_id  = 5'd4;
        comp_vld  = 1'b1;
        comp_id   = 5'd15;
        tick();
        claim_vld = 1'b0;
        comp_vld  = 1'b0;
        check("dual_ip", 32'(ip), 32'h0);
        check("dual_busy", 32'(busy), 32'h0010);
        irq[4] = 1'b0;
        tick();
        tick();
        comp(4);
        check("s4_clean", 32'({ip, busy}), 32'h0);

        // Edge source 7: three edges while BUSY.
        trig[7] = 1'b1;
        pulse(7);
        tick();
        check("e7_pend", 32'(ip[7]), 32'h1);
        claim(7);
        check("e7_busy", 32'(busy[7]), 32'h1);
        pulse(7);
        pulse(7);
        pulse(7);
        tick();
        tick();
        tick();
        comp(7);
`ifdef PLIC_GW_EDGE_CNT_EN
        for (int r = 0; r < 3; r++) begin
            check("e7_replay_pend", 32'(ip[7]), 32'h1);
            claim(7);
            check("e7_replay_busy", 32'(busy[7]), 32'h1);
            comp(7);
        end
`endif
        check("e7_final_idle", 32'({ip[7], busy[7]}), 32'h0);
        tick();
        check("e7_stays_idle", 32'(ip[7]), 32'h0);

        // Edge source 9: 20 edges while BUSY, count replays.
        trig[9] = 1'b1;
        pulse(9);
        tick();
        check("e9_pend", 32'(ip[9]), 32'h1);
        claim(9);
        for (int k = 0; k < 20; k++) begin
            pulse(9);
        end
        tick();
        tick();
        tick();
        comp(9);
        replays = 0;
        for (int k = 0; k < 20; k++) begin
            if (ip[9] !== 1'b1) break;
            replays++;
            claim(9);
            comp(9);
        end
`ifdef PLIC_GW_EDGE_CNT_EN
        exp_replays = 15;
`else
        exp_replays = 0;
`endif
        check("e9_replays", 32'(replays), 32'(exp_replays));
        check("e9_idle", 32'({ip[9], busy[9]}), 32'h0);

        // Asynchronous reset while source 2 is BUSY, level line held high.
        irq[2] = 1'b1;
        tick();
        tick();
        tick();
        claim(2);
        check("s2_busy", 32'(busy[2]), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ip", 32'(ip), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        #2 rst = 1'b0;
        tick();
        check("rst_rel_e1", 32'(ip[2]), 32'h0);
        tick();
        check("rst_rel_e2", 32'(ip[2]), 32'h0);
        tick();
        check("rst_rel_e3", 32'(ip[2]), 32'h1);

        // Switching trigger type must not disturb the pending state.
        trig[2] = 1'b1;
        tick();
        tick();
        check("trig_flip_pend", 32'({ip[2], busy[2]}), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
